// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception/interrupt controller.
package exc_ctrl_pkg;

  // Raw exception flags carried by the MEM-stage instruction (MSB first).
  typedef struct packed {
    logic adel_if;
    logic ri;
    logic sys;
    logic bp;
    logic ov;
    logic ades;
    logic adel_d;
    logic eret;
  } ExcVec_t;

  // MIPS Cause.ExcCode values used by this controller.
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } ExcCode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BUS,
    ST_FLUSH
  } ExcState_t;

  localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;

  // EPC points at the branch when the faulting instruction sits in a delay slot.
  function automatic logic [31:0] exc_epc_of(input logic [31:0] pc, input logic is_ds);
    return is_ds ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage handshake between the pipeline (master) and exc_ctrl (slave).
interface exc_ctrl_if;
  import exc_ctrl_pkg::*;

  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_is_ds;
  ExcVec_t     mem_exc;
  logic [31:0] mem_badvaddr;
  logic        mem_bus_busy;
  logic        stall_req;

  modport master (
    output mem_valid, mem_pc, mem_is_ds, mem_exc, mem_badvaddr, mem_bus_busy,
    input  stall_req
  );

  modport slave (
    input  mem_valid, mem_pc, mem_is_ds, mem_exc, mem_badvaddr, mem_bus_busy,
    output stall_req
  );
endinterface

// File: rtl/exc_int_sync.sv
// Hardware interrupt sampler. EXC_INT_SYNC_EN selects a two-flop
// synchroniser for asynchronous sources; otherwise a single register stage.
module exc_int_sync #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);
`ifdef EXC_INT_SYNC_EN
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage per-bit synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end
`else
  logic [WIDTH-1:0] r_sync;

  // Single sampling register for clk-synchronous sources.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= i_async;
  end
`endif

  assign o_sync = r_sync;
endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller at the MEM/WB boundary: prioritises causes,
// forwards WB CP0 writes, waits out D-bus transactions, then commits,
// redirects and flushes. Interrupt sampling depth set by EXC_INT_SYNC_EN.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned NUM_HW_INT = 6,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned FLUSH_HOLD = 1,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                  clk,
  input  logic                  rst,
  exc_ctrl_if.slave             mem_if,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic [31:0]           cp0_status,
  input  logic [31:0]           cp0_cause,
  input  logic [31:0]           cp0_epc,
  input  logic                  wb_cp0_we,
  input  logic [4:0]            wb_cp0_addr,
  input  logic [31:0]           wb_cp0_wdata,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic                  exc_commit,
  output logic [4:0]            exc_code,
  output logic [31:0]           exc_epc,
  output logic                  exc_bd,
  output logic                  badvaddr_we,
  output logic [31:0]           exc_badvaddr,
  output logic                  eret_commit,
  output logic [NUM_HW_INT-1:0] ip_hw
);

  localparam logic [2:0] HOLD_LAST = 3'(FLUSH_HOLD - 1);

  ExcState_t   r_state, w_state_nx;
  logic [2:0]  r_cnt, w_cnt_nx;
  logic [31:0] w_status, w_cause, w_epc;
  logic [7:0]  w_ip;
  logic        w_int_pend, w_event, w_accept, w_stall, w_commit;
  ExcCode_t    w_code;
  logic        w_is_eret, w_bv_we;
  logic [31:0] w_bv;
  ExcCode_t    r_code;
  logic [31:0] r_epc, r_badvaddr, r_redirect_pc;
  logic        r_bd, r_bv_we, r_is_eret;
  logic        w_unused;

  exc_int_sync #(.WIDTH(NUM_HW_INT)) u_int_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (hw_int),
    .o_sync  (ip_hw)
  );

  // Forward an in-flight WB write so decisions see the newest CP0 state.
  always_comb begin
    w_status = cp0_status;
    w_cause  = cp0_cause;
    w_epc    = cp0_epc;
    if (wb_cp0_we) begin
      case (wb_cp0_addr)
        CP0_ADDR_STATUS: w_status     = wb_cp0_wdata;
        CP0_ADDR_CAUSE:  w_cause[9:8] = wb_cp0_wdata[9:8];
        CP0_ADDR_EPC:    w_epc        = wb_cp0_wdata;
        default: ;
      endcase
    end
  end

  // Pending-interrupt vector: software bits from Cause, hardware bits from the sampler.
  always_comb begin
    w_ip = w_cause[15:8];
    w_ip[NUM_HW_INT+1:2] = ip_hw;
  end

  assign w_int_pend = (|(w_ip & w_status[15:8])) && !w_status[STATUS_EXL] && w_status[STATUS_IE];

  // Fixed-priority cause selection for the MEM-stage instruction.
  always_comb begin
    w_event   = mem_if.mem_valid;
    w_code    = EXC_INT;
    w_is_eret = 1'b0;
    w_bv_we   = 1'b0;
    w_bv      = mem_if.mem_badvaddr;
    if (w_int_pend)                  w_code = EXC_INT;
    else if (mem_if.mem_exc.adel_if) begin
      w_code  = EXC_ADEL;
      w_bv_we = 1'b1;
      w_bv    = mem_if.mem_pc;
    end
    else if (mem_if.mem_exc.ri)      w_code = EXC_RI;
    else if (mem_if.mem_exc.sys)     w_code = EXC_SYS;
    else if (mem_if.mem_exc.bp)      w_code = EXC_BP;
    else if (mem_if.mem_exc.ov)      w_code = EXC_OV;
    else if (mem_if.mem_exc.ades) begin
      w_code  = EXC_ADES;
      w_bv_we = 1'b1;
    end
    else if (mem_if.mem_exc.adel_d) begin
      w_code  = EXC_ADEL;
      w_bv_we = 1'b1;
    end
    else if (mem_if.mem_exc.eret)    w_is_eret = 1'b1;
    else                             w_event = 1'b0;
  end

  // FSM state and flush-hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next state; stall only while the bus is actually busy, so the falling
  // cycle of mem_bus_busy is already unstalled and commit lands one cycle later.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    w_stall    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_event) begin
          w_accept = 1'b1;
          if (mem_if.mem_bus_busy) begin
            w_stall    = 1'b1;
            w_state_nx = ST_WAIT_BUS;
          end else begin
            w_state_nx = ST_FLUSH;
          end
        end
      end
      ST_WAIT_BUS: begin
        w_stall = mem_if.mem_bus_busy;
        if (!mem_if.mem_bus_busy) w_state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 3'd1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Capture the accepted event; held until the next acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code        <= EXC_INT;
      r_epc         <= '0;
      r_bd          <= 1'b0;
      r_bv_we       <= 1'b0;
      r_badvaddr    <= '0;
      r_is_eret     <= 1'b0;
      r_redirect_pc <= '0;
    end else if (w_accept) begin
      r_code        <= w_code;
      r_epc         <= exc_epc_of(mem_if.mem_pc, mem_if.mem_is_ds);
      r_bd          <= mem_if.mem_is_ds;
      r_bv_we       <= w_bv_we;
      r_badvaddr    <= w_bv;
      r_is_eret     <= w_is_eret;
      r_redirect_pc <= w_is_eret ? w_epc : EXC_VECTOR;
    end
  end

  assign w_commit         = (r_state == ST_FLUSH) && (r_cnt == '0);
  assign mem_if.stall_req = w_stall;
  assign flush            = {NUM_STAGES{r_state == ST_FLUSH}};
  assign redirect_valid   = w_commit;
  assign redirect_pc      = r_redirect_pc;
  assign exc_commit       = w_commit && !r_is_eret;
  assign eret_commit      = w_commit && r_is_eret;
  assign badvaddr_we      = w_commit && r_bv_we;
  assign exc_code         = r_code;
  assign exc_epc          = r_epc;
  assign exc_bd           = r_bd;
  assign exc_badvaddr     = r_badvaddr;

  assign w_unused = ^{w_status[31:16], w_status[7:2], w_cause[31:16], w_cause[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  localparam int unsigned NHW  = 6;
  localparam int unsigned NST  = 4;
  localparam int unsigned HOLD = 3;
  localparam logic [31:0] VEC  = 32'hBFC0_0380;
`ifdef EXC_INT_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 1;
`endif

  localparam logic [7:0] F_ADELIF = 8'h80, F_RI = 8'h40, F_SYS = 8'h20, F_BP = 8'h10;
  localparam logic [7:0] F_OV = 8'h08, F_ADES = 8'h04, F_ADELD = 8'h02, F_ERET = 8'h01;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        bvwe;
    logic [31:0] bv;
    logic        eret;
    logic [31:0] rpc;
  } exp_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  exc;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bvin;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epcin;
    logic        wbwe;
    logic [4:0]  wbaddr;
    logic [31:0] wbdata;
    logic        ev;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exc_ctrl_if mif();
  logic [NHW-1:0] hw_int;
  logic [31:0]    cp0_status, cp0_cause, cp0_epc;
  logic           wb_cp0_we;
  logic [4:0]     wb_cp0_addr;
  logic [31:0]    wb_cp0_wdata;
  logic [NST-1:0] flush;
  logic           redirect_valid, exc_commit, exc_bd, badvaddr_we, eret_commit;
  logic [31:0]    redirect_pc, exc_epc, exc_badvaddr;
  logic [4:0]     exc_code;
  logic [NHW-1:0] ip_hw;

  exc_ctrl #(.NUM_HW_INT(NHW), .NUM_STAGES(NST), .FLUSH_HOLD(HOLD), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .mem_if(mif), .hw_int(hw_int),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .wb_cp0_we(wb_cp0_we), .wb_cp0_addr(wb_cp0_addr), .wb_cp0_wdata(wb_cp0_wdata),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_commit(exc_commit), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
    .badvaddr_we(badvaddr_we), .exc_badvaddr(exc_badvaddr),
    .eret_commit(eret_commit), .ip_hw(ip_hw)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mif.mem_valid = 1'b0; mif.mem_pc = '0; mif.mem_is_ds = 1'b0; mif.mem_exc = '0;
    mif.mem_badvaddr = '0; mif.mem_bus_busy = 1'b0;
    cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    wb_cp0_we = 1'b0; wb_cp0_addr = '0; wb_cp0_wdata = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    mif.mem_valid = v.valid; mif.mem_exc = ExcVec_t'(v.exc); mif.mem_pc = v.pc;
    mif.mem_is_ds = v.ds; mif.mem_badvaddr = v.bvin; mif.mem_bus_busy = 1'b0;
    cp0_status = v.status; cp0_cause = v.cause; cp0_epc = v.epcin;
    wb_cp0_we = v.wbwe; wb_cp0_addr = v.wbaddr; wb_cp0_wdata = v.wbdata;
  endtask

  // Starts at the drive point of the first FLUSH cycle; ends at the sample point after it.
  task automatic flush_seq(input string tag, input logic on);
    for (int k = 1; k <= int'(HOLD); k++) begin
      @(negedge clk);
      chk(tag, 32'(flush), on ? 32'hF : 32'h0);
      cyc();
    end
    @(negedge clk);
    chk({tag, "_end"}, 32'(flush), 32'h0);
  endtask

  // Scoreboard: every commit pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (redirect_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_commit: got redirect_pc %h expected no commit", redirect_pc);
        end else begin
          e = sbq.pop_front();
          chk("redirect_pc", redirect_pc, e.rpc);
          chk("eret_commit", 32'(eret_commit), 32'(e.eret));
          chk("exc_commit", 32'(exc_commit), 32'(!e.eret));
          if (!e.eret) begin
            chk("exc_code", 32'(exc_code), 32'(e.code));
            chk("exc_epc", exc_epc, e.epc);
            chk("exc_bd", 32'(exc_bd), 32'(e.bd));
            chk("badvaddr_we", 32'(badvaddr_we), 32'(e.bvwe));
            if (e.bvwe) chk("exc_badvaddr", exc_badvaddr, e.bv);
          end
        end
      end else if ((exc_commit | eret_commit | badvaddr_we) === 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_strobe: got commit strobe without redirect_valid expected none");
      end
    end
  end

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    summary();
    $finish;
  end

  localparam int NV = 19;
  vec_t tv[NV];

  initial begin
    tv[0]  = '{1'b1, F_OV,           32'h8000_0010, 1'b0, 32'h0,        32'h0,   32'h0,   32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd12, 32'h8000_0010, 1'b0, 1'b0, 32'h0,         1'b0, VEC}};
    tv[1]  = '{1'b1, F_SYS,          32'h8000_0024, 1'b1, 32'h0,        32'h0,   32'h0,   32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd8,  32'h8000_0020, 1'b1, 1'b0, 32'h0,         1'b0, VEC}};
    tv[2]  = '{1'b1, F_ADELIF|F_RI,  32'h8000_0003, 1'b0, 32'h5555,     32'h0,   32'h0,   32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd4,  32'h8000_0003, 1'b0, 1'b1, 32'h8000_0003, 1'b0, VEC}};
    tv[3]  = '{1'b1, F_RI|F_SYS,     32'h8000_0100, 1'b0, 32'h0,        32'h0,   32'h0,   32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd10, 32'h8000_0100, 1'b0, 1'b0, 32'h0,         1'b0, VEC}};
    tv[4]  = '{1'b1, F_SYS|F_BP|F_OV,32'h8000_0104, 1'b0, 32'h0,        32'h0,   32'h0,   32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd8,  32'h8000_0104, 1'b0, 1'b0, 32'h0,         1'b0, VEC}};
    tv[5]  = '{1'b1, F_BP|F_OV,      32'h8000_0108, 1'b0, 32'h0,        32'h0,   32'h0,   32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd9,  32'h8000_0108, 1'b0, 1'b0, 32'h0,         1'b0, VEC}};
    tv[6]  = '{1'b1, F_OV|F_ADES|F_ADELD, 32'h8000_010C, 1'b0, 32'h40,  32'h0,   32'h0,   32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd12, 32'h8000_010C, 1'b0, 1'b0, 32'h0,         1'b0, VEC}};
    tv[7]  = '{1'b1, F_ADES,         32'h8000_0110, 1'b0, 32'h1003,     32'h0,   32'h0,   32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd5,  32'h8000_0110, 1'b0, 1'b1, 32'h1003,      1'b0, VEC}};
    tv[8]  = '{1'b1, F_ADELD|F_ERET, 32'h8000_0114, 1'b0, 32'h2001,     32'h0,   32'h0,   32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd4,  32'h8000_0114, 1'b0, 1'b1, 32'h2001,      1'b0, VEC}};
    tv[9]  = '{1'b1, F_ERET,         32'h8000_0118, 1'b0, 32'h0,        32'h0,   32'h0,   32'h8000_0200, 1'b0, 5'd0,  32'h0,         1'b1, '{5'd0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0200}};
    tv[10] = '{1'b1, F_ERET,         32'h8000_011C, 1'b0, 32'h0,        32'h0,   32'h0,   32'h8000_0300, 1'b1, 5'd14, 32'h8000_1000, 1'b1, '{5'd0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_1000}};
    tv[11] = '{1'b1, F_ERET,         32'h8000_0120, 1'b0, 32'h0,        32'h0,   32'h0,   32'h8000_0300, 1'b1, 5'd12, 32'h0,         1'b1, '{5'd0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0300}};
    tv[12] = '{1'b1, F_SYS,          32'h0000_0000, 1'b1, 32'h0,        32'h0,   32'h0,   32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd8,  32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         1'b0, VEC}};
    tv[13] = '{1'b1, F_OV,           32'h8000_0120, 1'b0, 32'h0,        32'h101, 32'h0,   32'h0,         1'b1, 5'd13, 32'h100,       1'b1, '{5'd0,  32'h8000_0120, 1'b0, 1'b0, 32'h0,         1'b0, VEC}};
    tv[14] = '{1'b1, F_ERET,         32'h8000_0124, 1'b0, 32'h0,        32'h0,   32'h200, 32'h8000_0300, 1'b1, 5'd12, 32'h201,       1'b1, '{5'd0,  32'h8000_0124, 1'b0, 1'b0, 32'h0,         1'b0, VEC}};
    tv[15] = '{1'b1, F_SYS,          32'h8000_0128, 1'b0, 32'h0,        32'h101, 32'h100, 32'h0,         1'b1, 5'd13, 32'h0,         1'b1, '{5'd8,  32'h8000_0128, 1'b0, 1'b0, 32'h0,         1'b0, VEC}};
    tv[16] = '{1'b1, F_SYS,          32'h8000_012C, 1'b0, 32'h0,        32'h103, 32'h100, 32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd8,  32'h8000_012C, 1'b0, 1'b0, 32'h0,         1'b0, VEC}};
    tv[17] = '{1'b0, F_SYS|F_OV,     32'h8000_0200, 1'b0, 32'h0,        32'h0,   32'h0,   32'h0,         1'b0, 5'd0,  32'h0,         1'b0, '{5'd0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0}};
    tv[18] = '{1'b1, F_BP,           32'h8000_0130, 1'b1, 32'h0,        32'h100, 32'h100, 32'h0,         1'b0, 5'd0,  32'h0,         1'b1, '{5'd9,  32'h8000_012C, 1'b1, 1'b0, 32'h0,         1'b0, VEC}};

    // Reset
    rst = 1'b1;
    hw_int = '0;
    idle_inputs();
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_commits", {29'b0, exc_commit, eret_commit, badvaddr_we}, 32'h0);
    chk("rst_exc_code", 32'(exc_code), 32'h0);
    chk("rst_exc_epc", exc_epc, 32'h0);
    chk("rst_badvaddr", exc_badvaddr, 32'h0);
    chk("rst_bd", 32'(exc_bd), 32'h0);
    chk("rst_ip_hw", 32'(ip_hw), 32'h0);
    chk("rst_stall", 32'(mif.stall_req), 32'h0);

    // Single-cycle-accept vectors
    for (int i = 0; i < NV; i++) begin
      cyc();
      drive_vec(tv[i]);
      if (tv[i].ev) sbq.push_back(tv[i].e);
      @(negedge clk);
      chk("vec_stall", 32'(mif.stall_req), 32'h0);
      chk("vec_flush_pre", 32'(flush), 32'h0);
      cyc();
      idle_inputs();
      flush_seq("vec_flush", tv[i].ev);
    end

    // AdES with bus busy for 3 cycles; MEM inputs change while waiting
    cyc();
    mif.mem_valid = 1'b1; mif.mem_exc = ExcVec_t'(F_ADES); mif.mem_pc = 32'h8000_0040;
    mif.mem_badvaddr = 32'h0000_1003; mif.mem_bus_busy = 1'b1;
    sbq.push_back('{5'd5, 32'h8000_0040, 1'b0, 1'b1, 32'h0000_1003, 1'b0, VEC});
    @(negedge clk);
    chk("busy_stall_t0", 32'(mif.stall_req), 32'h1);
    cyc();
    mif.mem_exc = ExcVec_t'(F_OV); mif.mem_pc = 32'h9000_0000; mif.mem_badvaddr = 32'h0;
    @(negedge clk);
    chk("busy_stall_t1", 32'(mif.stall_req), 32'h1);
    cyc();
    @(negedge clk);
    chk("busy_stall_t2", 32'(mif.stall_req), 32'h1);
    cyc();
    mif.mem_bus_busy = 1'b0;
    @(negedge clk);
    chk("busy_stall_b", 32'(mif.stall_req), 32'h0);
    chk("busy_no_early_commit", 32'(redirect_valid), 32'h0);
    cyc();
    idle_inputs();
    flush_seq("busy_flush", 1'b1);

    // Hardware interrupt: sampling latency, EXL block, then Int commit
    cyc();
    cp0_status = 32'h0000_0403;
    hw_int = 6'b000001;
    for (int c = 0; c <= int'(SYNC_LAT); c++) begin
      @(negedge clk);
      chk("ip_hw_lag", 32'(ip_hw), (c >= int'(SYNC_LAT)) ? 32'h1 : 32'h0);
      cyc();
    end
    mif.mem_valid = 1'b1; mif.mem_pc = 32'h8000_0050;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("int_exl_no_flush", 32'(flush), 32'h0);
      cyc();
    end
    cp0_status = 32'h0000_0401;
    sbq.push_back('{5'd0, 32'h8000_0050, 1'b0, 1'b0, 32'h0, 1'b0, VEC});
    @(negedge clk);
    cyc();
    idle_inputs();
    hw_int = '0;
    flush_seq("int_flush", 1'b1);

    // Reset in the middle of FLUSH
    cyc();
    mif.mem_valid = 1'b1; mif.mem_exc = ExcVec_t'(F_SYS); mif.mem_pc = 32'h8000_0060;
    sbq.push_back('{5'd8, 32'h8000_0060, 1'b0, 1'b0, 32'h0, 1'b0, VEC});
    @(negedge clk);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("rstf_flush_c1", 32'(flush), 32'hF);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstf_flush_c2", 32'(flush), 32'hF);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rstf_flush_after", 32'(flush), 32'h0);
    chk("rstf_redirect_after", 32'(redirect_valid), 32'h0);
    cyc();
    mif.mem_valid = 1'b1; mif.mem_exc = ExcVec_t'(F_OV); mif.mem_pc = 32'h8000_0070;
    sbq.push_back('{5'd12, 32'h8000_0070, 1'b0, 1'b0, 32'h0, 1'b0, VEC});
    @(negedge clk);
    cyc();
    idle_inputs();
    flush_seq("rstf_post_flush", 1'b1);

    // Reset in the middle of WAIT_BUS: nothing may commit afterwards
    cyc();
    mif.mem_valid = 1'b1; mif.mem_exc = ExcVec_t'(F_ADES); mif.mem_pc = 32'h8000_0080;
    mif.mem_bus_busy = 1'b1;
    @(negedge clk);
    chk("rstw_stall", 32'(mif.stall_req), 32'h1);
    cyc();
    mif.mem_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rstw_no_flush", 32'(flush), 32'h0);
      cyc();
    end

    repeat (3) cyc();
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    summary();
    $finish;
  end

endmodule
